// File: rtl/vga_pkg.sv
// Shared VGA timing constants and types; also used by the downstream tile mapper stage.
package vga_pkg;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam int unsigned DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned COORD_MAX = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   hs;
    logic   vs;
    logic   blank;
  } vga_timing_t;

  // Half-open window test: lo <= v < hi.
  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter for one raster axis: counts 0..TOTAL-1 while enabled, flags the last value.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL = DEF_H_TOTAL
) (
  input  logic   gclk,
  input  logic   grst_n,
  input  logic   en_i,
  output coord_t cnt_o,
  output logic   tc_o
);

  localparam coord_t LAST = coord_t'(TOTAL - 1);

  if (TOTAL > COORD_MAX || TOTAL < 2) begin : g_total_chk
    $error("vga_axis_counter: TOTAL must be in 2..1024");
  end

  coord_t cnt_q, cnt_d;
  logic   tc;

  assign tc = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = tc ? '0 : cnt_q + coord_t'(1);
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  // Terminal count is not gated by en_i; the vertical axis only ever sees it through the horizontal one.
  assign tc_o  = tc;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: free-running h/v counters plus one register stage of decoded outputs.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT     = DEF_H_FRONT,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BACK      = DEF_H_BACK,
  parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT     = DEF_V_FRONT,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BACK      = DEF_V_BACK,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_width_chk
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam coord_t H_VIS_END = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_END = coord_t'(V_VISIBLE);
  localparam coord_t HS_START  = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END    = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_START  = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END    = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam vga_timing_t TIMING_RST = '{
    x: '0, y: '0, hs: ~SYNC_ACTIVE, vs: ~SYNC_ACTIVE, blank: 1'b0
  };

  coord_t hc, vc;
  logic   h_tc;
  logic   v_tc_unused;

  vga_axis_counter #(.TOTAL(H_TOTAL)) u_hcnt (
    .gclk   (vga_clk),
    .grst_n (reset_n),
    .en_i   (1'b1),
    .cnt_o  (hc),
    .tc_o   (h_tc)
  );

  // Vertical advances only on the horizontal wrap, so vs naturally changes on line boundaries.
  vga_axis_counter #(.TOTAL(V_TOTAL)) u_vcnt (
    .gclk   (vga_clk),
    .grst_n (reset_n),
    .en_i   (h_tc),
    .cnt_o  (vc),
    .tc_o   (v_tc_unused)
  );

  vga_timing_t timing_d, timing_q;
  logic        line_start_d, line_start_q;
  logic        frame_start_d, frame_start_q;

  always_comb begin
    timing_d       = TIMING_RST;
    timing_d.x     = hc;
    timing_d.y     = vc;
    timing_d.blank = (hc < H_VIS_END) && (vc < V_VIS_END);
    timing_d.hs    = in_window(hc, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    timing_d.vs    = in_window(vc, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    line_start_d   = (hc == '0);
    frame_start_d  = (hc == '0) && (vc == '0);
  end

  // Every output comes from this one stage so all of them describe the same pixel.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      timing_q      <= TIMING_RST;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      timing_q      <= timing_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign DrawX       = timing_q.x;
  assign DrawY       = timing_q.y;
  assign hs          = timing_q.hs;
  assign vs          = timing_q.vs;
  assign blank       = timing_q.blank;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: raster-order reference model checked every cycle plus directed checks.
// Horizontal timing is the real 640-wide line; the vertical axis is shortened to keep frames short.
module tb_vga_timing_gen;

  localparam int HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int HT = HV + HF + HS + HB;
  localparam int VV = 24, VF = 3, VS = 2, VB = 4;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       ls;
    logic       fs;
  } pix_t;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] DrawX, DrawY;
  logic       hs, vs, blank, line_start, frame_start;

  int checks = 0;
  int fails  = 0;
  int unsigned edges = 0;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE(1'b0)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n),
    .DrawX(DrawX), .DrawY(DrawY), .hs(hs), .vs(vs), .blank(blank),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 vga_clk = ~vga_clk;

  // Model: edge N after reset presents raster pixel N-1; everything follows from (x,y).
  function automatic pix_t model(int unsigned e);
    pix_t p;
    int unsigned idx, x, y;
    p = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, blank: 1'b0, ls: 1'b0, fs: 1'b0};
    if (e == 0) return p;
    idx = (e - 1) % FRAME;
    x = idx % HT;
    y = idx / HT;
    p.x     = 10'(x);
    p.y     = 10'(y);
    p.blank = (x < HV) && (y < VV);
    p.hs    = !((x >= HV + HF) && (x < HV + HF + HS));
    p.vs    = !((y >= VV + VF) && (y < VV + VF + VS));
    p.ls    = (x == 0);
    p.fs    = (idx == 0);
    return p;
  endfunction

  function automatic pix_t dut_pix();
    return '{x: DrawX, y: DrawY, hs: hs, vs: vs, blank: blank, ls: line_start, fs: frame_start};
  endfunction

  always @(posedge vga_clk or negedge reset_n)
    if (!reset_n) edges <= 0;
    else          edges <= edges + 1;

  pix_t exp_p, got_p;
  always @(negedge vga_clk) begin
    exp_p = model(edges);
    got_p = dut_pix();
    checks++;
    if (got_p !== exp_p) begin
      fails++;
      if (fails <= 20)
        $display("FAIL cycle_compare @%0t: got x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b, expected x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b",
                 $time, got_p.x, got_p.y, got_p.hs, got_p.vs, got_p.blank, got_p.ls, got_p.fs,
                 exp_p.x, exp_p.y, exp_p.hs, exp_p.vs, exp_p.blank, exp_p.ls, exp_p.fs);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  int hs_lo, hs_first, hs_last, blank_fall, ls2, vs_lo, vs_first_y, fs2, blank_cnt, maxx, maxy, wrap_ok, n;
  logic [9:0] px, py;

  initial begin
    // Pin the model against hand-computed pixels.
    check("model_pix0",  32'(model(1)),  32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}));
    check("model_hs656", 32'(model(657)), 32'({10'd656, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
    check("model_vs27",  32'(model(27 * 800 + 1)), 32'({10'd0, 10'd27, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}));

    repeat (10) step();
    check("rst_pixel", 32'(dut_pix()), 32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
    @(negedge vga_clk); #1 reset_n = 1'b1;

    step();
    check("edge1_x", DrawX, 0);
    check("edge1_y", DrawY, 0);
    check("edge1_blank", blank, 1);
    check("edge1_fs", frame_start, 1);
    check("edge1_hsvs", {hs, vs}, 2'b11);

    hs_lo = 0; hs_first = -1; hs_last = -1; blank_fall = -1; ls2 = -1;
    vs_lo = 0; vs_first_y = -1; fs2 = -1; blank_cnt = int'(blank);
    maxx = 0; maxy = 0; wrap_ok = -1;
    for (int i = 1; i <= FRAME; i++) begin
      px = DrawX; py = DrawY;
      step();
      if (i < FRAME && blank) blank_cnt++;
      if (i < HT) begin
        if (!hs) begin
          hs_lo++;
          if (hs_first < 0) hs_first = int'(DrawX);
          hs_last = int'(DrawX);
        end
        if (!blank && blank_fall < 0) blank_fall = int'(DrawX);
      end
      if (line_start && ls2 < 0) ls2 = i;
      if (i < FRAME && !vs) begin
        vs_lo++;
        if (vs_first_y < 0) vs_first_y = int'(DrawY);
      end
      if (frame_start && fs2 < 0) fs2 = i;
      if (int'(DrawX) > maxx) maxx = int'(DrawX);
      if (int'(DrawY) > maxy) maxy = int'(DrawY);
      if (px == 10'd799 && py == 10'(VT - 1))
        wrap_ok = (DrawX == 10'd0 && DrawY == 10'd0 && frame_start) ? 1 : 0;
    end
    check("hs_low_cycles", hs_lo, 96);
    check("hs_first_x", hs_first, 656);
    check("hs_last_x", hs_last, 751);
    check("blank_fall_x", blank_fall, 640);
    check("line_start_spacing", ls2, 800);
    check("vs_low_cycles", vs_lo, 1600);
    check("vs_first_y", vs_first_y, 27);
    check("frame_start_spacing", fs2, 26400);
    check("blank_count", blank_cnt, 15360);
    check("max_drawx", maxx, 799);
    check("max_drawy", maxy, 32);
    check("wrap_to_origin", wrap_ok, 1);

    n = 0;
    while (!(DrawX == 10'd300 && DrawY == 10'd20) && n < FRAME) begin
      step();
      n++;
    end
    check("reach_300_20", n < FRAME, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_pixel", 32'(dut_pix()), 32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
    repeat (3) @(negedge vga_clk);
    #1 reset_n = 1'b1;
    step();
    check("rerelease_x", DrawX, 0);
    check("rerelease_y", DrawY, 0);
    check("rerelease_fs", frame_start, 1);
    repeat (1000) step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 VGA raster timing from vga_clk (25 MHz pixel clock).
- Drives DrawX/DrawY/blank into the downstream tile-drawing mapper, and hs/vs to the DAC connector.
- Also emits line_start/frame_start strobes for frame-synchronous logic (sprite/tile updates).
- All outputs are registered and mutually aligned; each output describes the same pixel in the same cycle.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks); H_TOTAL = sum = 800
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines); V_TOTAL = sum = 525
- SYNC_ACTIVE, 1'b0, level of hs/vs while asserted (0 = active-low)

Ports:
- vga_clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- DrawX  out  10  horizontal pixel index, 0..H_TOTAL-1
- DrawY  out  10  vertical line index, 0..V_TOTAL-1
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- blank  out  1  1 = visible region (display enable), 0 = blanking
- line_start  out  1  one-cycle pulse, DrawX==0
- frame_start  out  1  one-cycle pulse, DrawX==0 and DrawY==0

Behaviour:
- One clock (vga_clk); reset is asynchronous and active-low (reset_n); every register is cleared or set immediately on reset_n low, regardless of clock.
- Internal counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1), 10 bits each; both reset to 0.
- hc increments every cycle; at H_TOTAL-1 it wraps to 0 and vc increments.
- vc wraps from V_TOTAL-1 to 0 on the same cycle hc wraps. No other gating, no stall input.
- Output stage: on each rising edge, outputs load values decoded from the current (hc,vc), so outputs lag the counters by exactly 1 cycle. Decode:
  - DrawX=hc, DrawY=vc
  - blank = (hc<H_VISIBLE) && (vc<V_VISIBLE)
  - hs = SYNC_ACTIVE iff H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC (656..751), else ~SYNC_ACTIVE
  - vs = SYNC_ACTIVE iff V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC (490..491), full lines, changes only on hc wrap
  - line_start = (hc==0); frame_start = (hc==0)&&(vc==0)
- Reset values: DrawX=0, DrawY=0, hs=~SYNC_ACTIVE, vs=~SYNC_ACTIVE, blank=0, line_start=0, frame_start=0.
- After reset release, edge 1 presents pixel (0,0): blank=1, line_start=1, frame_start=1. Edge N presents pixel N-1 in raster order.
- Frame period exactly H_TOTAL*V_TOTAL = 420000 cycles; frame_start spacing exactly 420000; line_start spacing exactly 800.
- Reset asserted mid-frame: outputs go to reset values asynchronously; on release the sequence restarts at (0,0) with no partial-frame artefacts.
- Downstream mapper adds its own ROM + output-register latency. This block does not compensate; the top level delays hs/vs to match.
- Width rule: parameters must satisfy H_TOTAL, V_TOTAL <= 1024; elaboration-time assertion otherwise.

Decomposition:
- Package vga_pkg:
  - timing constants (H_*/V_* defaults, H_TOTAL, V_TOTAL)
  - typedef logic [9:0] coord_t
  - struct vga_timing_t {coord_t x, y; logic hs, vs, blank}, reused by the mapper stage.
- One natural sub-module: vga_axis_counter (parameterised wrap counter with terminal-count output), instantiated once for horizontal and once for vertical (vertical enabled by horizontal terminal count).

Test Plan:
- Reset held 10 cycles then released -> outputs at reset values during reset; edge 1: DrawX=0, DrawY=0, blank=1, frame_start=1, hs=vs=1.
- Run one line -> blank falls when DrawX=640; hs=0 exactly for DrawX 656..751 (96 cycles); line_start pulses at DrawX=0 and again 800 cycles later.
- Run one full frame -> blank=0 for DrawY 480..524; vs=0 exactly for DrawY 490..491 (1600 cycles); next frame_start exactly 420000 cycles after the first.
- Wrap boundary at (799,524) -> next presented pixel is (0,0) with frame_start=1; DrawY never reaches 525; DrawX never reaches 800.
- Assert reset_n low asynchronously at (300,200), mid-cycle -> outputs return to reset values before the next edge; after release, edge 1 shows (0,0), frame_start=1.
- Count blank=1 cycles over one frame -> exactly 307200 (640*480).
